adder_seq_scheduler: RTL and testbench
======================================

# adder_seq_scheduler

- Shares one SEG-bit slice of the ripple adder chain among four requesters.
- Each accepted request is summed over WIDTH/SEG clock cycles, least-significant segment first, with the carry registered between segments.
- Sits between the requesting datapath units and the arithmetic resource: it arbitrates, sequences the carry chain, and returns a WIDTH+1-bit sum tagged with the requester index.

## Interface
Parameters:
- WIDTH, 16, operand width. Must be a multiple of SEG.
- SEG, 4, bits added per cycle. K = WIDTH/SEG is the number of add cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester request; bit i belongs to requester i.
- req_ready  out  4  one-hot accept pulse, high for one cycle in the capture cycle.
- req_a0  in  4*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_a1  in  4*WIDTH  operand B; same packing as req_a0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  a0 + a1; the MSB is the final carry.
- out_id  out  2  index of the requester that owns out_sum.

## Operation
States: IDLE, ADD, DONE.

- **IDLE**
  - If any req_valid bit is set: grant one requester, assert its req_ready bit, and capture its a0/a1 into internal registers.
  - Clear the carry and segment counter; go to ADD.
  - If no req_valid bit is set: stay in IDLE.
- **ADD** (exactly K cycles)
  - Cycle j computes {c, s} = a0[j*SEG +: SEG] + a1[j*SEG +: SEG] + carry.
  - s is written into sum[j*SEG +: SEG]; c goes into the carry register.
  - After segment K-1, sum[WIDTH] = carry. Go to DONE.
- **DONE**
  - out_valid = 1; out_sum and out_id are held stable.
  - On out_valid && out_ready: go to IDLE.
  - No grant is made in DONE; the next grant can come no earlier than the following IDLE cycle.
- **Arbitration**
  - Round-robin from pointer ptr (2 bits). Search order: ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - After a grant to requester g, ptr = g+1 (mod 4).
  - ptr = 0 after reset.
- **Requester contract**
  - A requester holds req_valid and its operands until it sees its req_ready bit.
  - req_valid dropping before the grant is allowed; that requester is simply not granted.
  - Operand changes after the grant have no effect, because operands are captured.
- **Reset**
  - rst wins over every other event in the same cycle.
  - If asserted in any state, mid-ADD included, the in-flight operation is discarded.

## Timing
- **Reset values:**
  - Outputs: req_ready = 0, out_valid = 0, out_sum = 0, out_id = 0.
  - Internal: state = IDLE, ptr = 0, carry = 0, segment counter = 0.
- **Latency:**
  - Grant in cycle T.
  - ADD during cycles T+1 to T+K.
  - out_valid high from cycle T+K+1.
- **Throughput:** with out_ready held at 1, one result every K+2 cycles.
- **Output-side handshake:**
  - out_valid stays high until out_ready is sampled high.
  - out_ready high outside DONE is ignored.
- **Simultaneous requests:** exactly one grant per IDLE cycle; req_ready is never multi-hot.
- **Carry wrap:** sum is WIDTH+1 bits and the final carry always lands in out_sum[WIDTH]. There is no overflow loss.

## Configuration
- ADDER_SEQ_SCHED_FIXED_PRIO_EN
  - **Defined:** fixed priority; the lowest index among the asserted req_valid bits wins. ptr is not implemented or updated.
  - **Undefined (default):** round-robin as described under Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
All scenarios use WIDTH=16, SEG=4, so K=4.
- **Single request, full carry ripple.** req_valid=0001, a0=0xFFFF, a1=0x0001.
  - req_ready=0001 for one cycle (T).
  - out_valid at T+5 with out_sum=0x10000, out_id=0.
- **All four request after reset, out_ready=1.** Each requester uses a0=0x1234, a1=0x1111.
  - Grant order is 0, 1, 2, 3, spaced 6 cycles apart.
  - Every result is out_sum=0x02345.
- **Backpressure.** out_ready=0 for 10 cycles while in DONE.
  - out_valid, out_sum and out_id stay stable.
  - req_ready stays 0.
  - Raising out_ready returns to IDLE on the next cycle.
- **Reset mid-operation.** rst=1 during the 2nd ADD cycle of a0=0x8000, a1=0x8000.
  - Next cycle: out_valid=0, req_ready=0, state IDLE.
  - The discarded result never appears.
  - After rst drops, the first grant goes to requester 0.
- **Fairness with two requesters.** Requesters 0 and 2 hold req_valid continuously.
  - Grants alternate 0, 2, 0, 2; out_id matches the order.
  - 0xAAAA+0x5555 gives 0x0FFFF; 0xFFFF+0xFFFF gives 0x1FFFE.
- **Fixed-priority build.** Repeat the fairness scenario with ADDER_SEQ_SCHED_FIXED_PRIO_EN defined.
  - Every grant goes to requester 0.
  - Requester 2 is granted only after req_valid[0] drops.

Source files
------------

// File: rtl/adder_seq_scheduler.sv
// Four-way arbiter around a shared SEG-bit adder slice; each request is summed over WIDTH/SEG cycles.
// Define ADDER_SEQ_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module adder_seq_scheduler #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [4*WIDTH-1:0] req_a0,
  input  logic [4*WIDTH-1:0] req_a1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [1:0]         out_id
);

  localparam int K  = WIDTH / SEG;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a0_q, a1_q;
  logic [WIDTH:0]   sum_q;
  logic             carry_q;
  logic [CW-1:0]    seg_q;
  logic [1:0]       id_q;
  logic             grant_any;
  logic [1:0]       grant_id;
  logic [SEG:0]     seg_sum;
  logic             last_seg;

`ifdef ADDER_SEQ_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr_q;

  // Search starts at ptr and wraps; the 2-bit add gives the modulo-4 for free.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!grant_any && req_valid[ptr_q + 2'(k)]) begin
        grant_any = 1'b1;
        grant_id  = ptr_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= 2'd0;
    else if (state == IDLE && grant_any)
      ptr_q <= grant_id + 2'd1;
  end
`endif

  always_comb begin
    seg_sum  = {1'b0, a0_q[seg_q*SEG +: SEG]} + {1'b0, a1_q[seg_q*SEG +: SEG]}
             + {{SEG{1'b0}}, carry_q};
    last_seg = (seg_q == CW'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 4'b0000;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = ADD;
          req_ready = 4'b0001 << grant_id;
        end
      end
      ADD:     if (last_seg) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst)
      req_ready = 4'b0000;
  end

  // The final segment's carry-out becomes sum[WIDTH], so nothing overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      a0_q    <= '0;
      a1_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      seg_q   <= '0;
      id_q    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a0_q    <= req_a0[grant_id*WIDTH +: WIDTH];
            a1_q    <= req_a1[grant_id*WIDTH +: WIDTH];
            id_q    <= grant_id;
            sum_q   <= '0;
            carry_q <= 1'b0;
            seg_q   <= '0;
          end
        end
        ADD: begin
          sum_q[seg_q*SEG +: SEG] <= seg_sum[SEG-1:0];
          carry_q                 <= seg_sum[SEG];
          if (last_seg) begin
            sum_q[WIDTH] <= seg_sum[SEG];
            seg_q        <= '0;
          end else begin
            seg_q <= seg_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_sum   = sum_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_adder_seq_scheduler.sv
// Scoreboard bench for adder_seq_scheduler: expected sums are queued when requests are
// raised and popped by a monitor at each output handshake.
module tb_adder_seq_scheduler;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*WIDTH-1:0] req_a0;
  logic [4*WIDTH-1:0] req_a1;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_sum;
  logic [1:0]         out_id;

  adder_seq_scheduler #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]     id;
    logic [WIDTH:0] sum;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] opA[4];
  logic [WIDTH-1:0] opB[4];
  logic [3:0]       pendMask;
  logic [3:0]       dropMask;
  bit               holdMode;
  int               grantLog[$];
  int               grantCyc[$];
  int               lastRise;
  logic             prevValid;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    opA[id]      = a;
    opB[id]      = b;
    pendMask[id] = 1'b1;
  endtask

  task automatic pushExpected(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.id  = 2'(id);
    e.sum = {1'b0, a} + {1'b0, b};
    sb.push_back(e);
  endtask

  // One clock: requesters drop after seeing their grant, new requests go up, then sample.
  task automatic cycleStep();
    @(negedge clk);
    req_valid = (req_valid & ~dropMask) | pendMask;
    dropMask  = 4'b0000;
    pendMask  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_a0[i*WIDTH +: WIDTH] = opA[i];
      req_a1[i*WIDTH +: WIDTH] = opB[i];
    end
    #2;
    if (req_ready != 4'b0000) begin
      checkOutput("ready_onehot", $countones(req_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          grantLog.push_back(i);
          grantCyc.push_back(cyc);
        end
      end
      if (!holdMode) dropMask = req_ready;
    end
    if (out_valid && !prevValid) lastRise = cyc;
    prevValid = out_valid;
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      cycleStep();
      n++;
    end
    if (!out_valid) checkOutput("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycleStep();
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    cycleStep();
    cycleStep();
  endtask

  task automatic waitGrants(input int count, input int budget);
    int n = 0;
    while (grantLog.size() < count && n < budget) begin
      cycleStep();
      n++;
    end
    if (grantLog.size() < count) checkOutput("grant_timeout", 32'(grantLog.size()), 32'(count));
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    req_valid = 4'b0000;
    pendMask  = 4'b0000;
    dropMask  = 4'b0000;
    holdMode  = 1'b0;
    cycleStep();
    cycleStep();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_id", 32'(out_id), 32'd0);
    rst = 1'b0;
    grantLog.delete();
    grantCyc.delete();
  endtask

  // Output monitor: every accepted result must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 32'(out_sum), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("out_id", 32'(out_id), 32'(e.id));
          checkOutput("out_sum", 32'(out_sum), 32'(e.sum));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a0    = '0;
    req_a1    = '0;
    out_ready = 1'b0;
    prevValid = 1'b0;
    lastRise  = 0;
    for (int i = 0; i < 4; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    $display("[TB] single request, full carry ripple");
    resetDut();
    out_ready = 1'b1;
    applyStimulus(0, 16'hFFFF, 16'h0001);
    pushExpected(0, 16'hFFFF, 16'h0001);
    cycleStep();
    checkOutput("s1_grant", 32'(req_ready), 32'h1);
    cycleStep();
    checkOutput("s1_ready_pulse", 32'(req_ready), 32'h0);
    waitValid(10);
    checkOutput("s1_latency", 32'(lastRise - grantCyc[0]), 32'd5);
    waitDrain(10);

    $display("[TB] four requesters after reset");
    resetDut();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 16'h1234, 16'h1111);
      pushExpected(i, 16'h1234, 16'h1111);
    end
    waitDrain(60);
    checkOutput("s2_grant_count", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < grantLog.size(); i++) begin
      checkOutput("s2_grant_order", 32'(grantLog[i]), 32'(i));
      if (i > 0) checkOutput("s2_grant_spacing", 32'(grantCyc[i] - grantCyc[i-1]), 32'd6);
    end

    $display("[TB] backpressure in DONE");
    resetDut();
    out_ready = 1'b0;
    applyStimulus(1, 16'h0F0F, 16'h00F1);
    pushExpected(1, 16'h0F0F, 16'h00F1);
    waitValid(10);
    applyStimulus(3, 16'h0001, 16'h0002);
    pushExpected(3, 16'h0001, 16'h0002);
    for (int i = 0; i < 10; i++) begin
      cycleStep();
      checkOutput("s3_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("s3_hold_sum", 32'(out_sum), 32'h01000);
      checkOutput("s3_hold_id", 32'(out_id), 32'd1);
      checkOutput("s3_no_grant", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    cycleStep();
    checkOutput("s3_back_idle", 32'(out_valid), 32'd0);
    checkOutput("s3_next_grant", 32'(req_ready), 32'h8);
    waitDrain(20);

    $display("[TB] reset during the second add cycle");
    resetDut();
    out_ready = 1'b1;
    applyStimulus(2, 16'h8000, 16'h8000);
    cycleStep();
    checkOutput("s4_grant", 32'(req_ready), 32'h4);
    cycleStep();
    cycleStep();
    rst = 1'b1;
    cycleStep();
    checkOutput("s4_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("s4_rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    applyStimulus(0, 16'h0003, 16'h0004);
    applyStimulus(3, 16'h0100, 16'h0200);
    pushExpected(0, 16'h0003, 16'h0004);
    pushExpected(3, 16'h0100, 16'h0200);
    cycleStep();
    checkOutput("s4_first_grant", 32'(req_ready), 32'h1);
    waitDrain(40);

    $display("[TB] two requesters holding valid");
    resetDut();
    out_ready = 1'b1;
    holdMode  = 1'b1;
    applyStimulus(0, 16'hAAAA, 16'h5555);
    applyStimulus(2, 16'hFFFF, 16'hFFFF);
`ifdef ADDER_SEQ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) pushExpected(0, 16'hAAAA, 16'h5555);
    pushExpected(2, 16'hFFFF, 16'hFFFF);
    waitGrants(3, 40);
    dropMask = 4'b0001;
    waitGrants(4, 40);
    dropMask = 4'b0100;
    holdMode = 1'b0;
    waitDrain(40);
    for (int i = 0; i < grantLog.size(); i++)
      checkOutput("s5_grant_order", 32'(grantLog[i]), (i < 3) ? 32'd0 : 32'd2);
`else
    for (int i = 0; i < 2; i++) begin
      pushExpected(0, 16'hAAAA, 16'h5555);
      pushExpected(2, 16'hFFFF, 16'hFFFF);
    end
    waitGrants(4, 40);
    dropMask = 4'b0101;
    holdMode = 1'b0;
    waitDrain(40);
    for (int i = 0; i < grantLog.size(); i++)
      checkOutput("s5_grant_order", 32'(grantLog[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
`endif
    checkOutput("s5_grant_count", 32'(grantLog.size()), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
